// File: rtl/button_in.sv
// button_in: four debounced push buttons behind a small MMIO read port.
// Reads return level (STATUS) or latched press events (EVENT, read-to-clear).
//
// Ports:
//   clock        system clock, rising-edge
//   reset        asynchronous, active-high
//   btn_n[3:0]   raw active-low buttons, asynchronous to clock
//   mmio_addr    read address, sampled with mmio_rd_en
//   mmio_rd_en   one-cycle read strobe
//   mmio_rdata   registered read data, held between reads
//   mmio_rvalid  one-cycle pulse qualifying mmio_rdata
//   irq          registered OR of the EVENT bits
module button_in #(
    parameter int unsigned DEBOUNCE_CYCLES = 27000,
    parameter logic [15:0] STATUS_ADDR     = 16'hf010,
    parameter logic [15:0] EVENT_ADDR      = 16'hf011
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  btn_n,
    input  logic [15:0] mmio_addr,
    input  logic        mmio_rd_en,
    output logic [7:0]  mmio_rdata,
    output logic        mmio_rvalid,
    output logic        irq
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [3:0]  sync1_q;
    logic [3:0]  sync2_q;
    logic [15:0] cnt_q [4];
    logic [15:0] cnt_d [4];
    logic [3:0]  level_q;
    logic [3:0]  level_d;
    logic [3:0]  event_q;
    logic [3:0]  event_d;
    logic [7:0]  rdata_q;
    logic [7:0]  rdata_d;
    logic        rvalid_q;
    logic        rvalid_d;
    logic        irq_q;
    logic        irq_d;

    logic [3:0]  rise;
    logic [3:0]  clr;
    logic        rd_status;
    logic        rd_event;
    logic        rd_other;

    // Debounce: a level flips only after the synchronized value has
    // disagreed with it for DEBOUNCE_CYCLES consecutive edges; any
    // agreement restarts the count.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = 16'd0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign rise = level_d & ~level_q;

    assign rd_status = mmio_rd_en && (mmio_addr == STATUS_ADDR);
    assign rd_event  = mmio_rd_en && (mmio_addr == EVENT_ADDR);
    assign rd_other  = mmio_rd_en && !rd_status && !rd_event;

    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = mmio_rd_en;
        clr      = 4'b0000;
        unique case (1'b1)
            rd_status: rdata_d = {4'b0000, level_q};
            rd_event: begin
                rdata_d = {4'b0000, event_q};
                clr     = event_q;
            end
            rd_other: rdata_d = 8'h00;
            default: ;
        endcase
    end

    // A press landing on the same edge as an EVENT read survives the clear.
    assign event_d = (event_q & ~clr) | rise;
    assign irq_d   = |event_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= 4'b0000;
            sync2_q  <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 16'd0;
            end
            level_q  <= 4'b0000;
            event_q  <= 4'b0000;
            rdata_q  <= 8'h00;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            sync1_q  <= ~btn_n;
            sync2_q  <= sync1_q;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q  <= level_d;
            event_q  <= event_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            irq_q    <= irq_d;
        end
    end

    assign mmio_rdata  = rdata_q;
    assign mmio_rvalid = rvalid_q;
    assign irq         = irq_q;

endmodule

// File: doc/button_in.md
BUTTON_IN -- requirements
Module: button_in

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 27000, meaning the consecutive stable cycles required before a debounced level changes (legal range 2..65535).
REQ-002 The block SHALL have parameter STATUS_ADDR, default 16'hf010, meaning the MMIO address of the read-only STATUS register.
REQ-003 The block SHALL have parameter EVENT_ADDR, default 16'hf011, meaning the MMIO address of the read-to-clear EVENT register.
REQ-004 The block SHALL have port clock, input, 1 bit: the system clock; all logic is rising-edge triggered.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port btn_n, input, 4 bits: raw push buttons, active-low, asynchronous to clock.
REQ-007 The block SHALL have port mmio_addr, input, 16 bits: the read address, sampled when mmio_rd_en=1.
REQ-008 The block SHALL have port mmio_rd_en, input, 1 bit: a one-cycle read strobe.
REQ-009 The block SHALL have port mmio_rdata, output, 8 bits: registered read data.
REQ-010 The block SHALL have port mmio_rvalid, output, 1 bit: a one-cycle pulse qualifying mmio_rdata.
REQ-011 The block SHALL have port irq, output, 1 bit: high while any EVENT bit is set.

Function
REQ-012 Each btn_n bit SHALL pass through a two-flop synchronizer; sync value = ~btn_n after 2 edges (1 = pressed).
REQ-013 Each button SHALL have an independent 16-bit debounce counter and a debounced level bit.
REQ-014 When the synchronized value equals the level, the counter SHALL be 0 on the next edge.
REQ-015 When the values differ and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-016 When the values differ and counter == DEBOUNCE_CYCLES-1, the level SHALL take the synchronized value and the counter SHALL return to 0 on the same edge.
REQ-017 Net latency from a btn_n change (held stable) to the level update SHALL be exactly 2+DEBOUNCE_CYCLES rising edges; any shorter pulse SHALL produce no level change.
REQ-018 A level 0->1 transition SHALL set the corresponding EVENT bit on the same edge; a 1->0 transition SHALL NOT affect EVENT.
REQ-019 STATUS read data SHALL be {4'b0, level[3:0]}; EVENT read data SHALL be {4'b0, event[3:0]}.
REQ-020 A read with mmio_rd_en=1 at edge N SHALL produce mmio_rdata and mmio_rvalid=1 at edge N+1; mmio_rvalid SHALL be 0 in all other cycles.
REQ-021 mmio_rdata SHALL hold its last value while mmio_rvalid=0.
REQ-022 A read of any address other than STATUS_ADDR/EVENT_ADDR SHALL return 8'h00 with mmio_rvalid=1 and no side effects.
REQ-023 An EVENT read SHALL clear exactly the bits returned, at the same edge the data is registered.
REQ-024 If a new press event occurs on the same edge as an EVENT read, the read SHALL return the pre-edge value and the new bit SHALL remain set afterwards (set wins over clear).
REQ-025 A STATUS read SHALL have no side effects.
REQ-026 Back-to-back reads on consecutive cycles SHALL each produce one rvalid pulse, in order.
REQ-027 irq SHALL be registered and equal to the OR of the EVENT bits, updating on the same edge as EVENT.

Reset
REQ-028 On reset assertion, the block SHALL asynchronously force: synchronizer flops to 0 (released), counters 0, levels 0, EVENT 0, mmio_rdata 8'h00, mmio_rvalid 0, irq 0.
REQ-029 A read issued in the cycle reset asserts SHALL be discarded: no rvalid after reset release.
REQ-030 Buttons held pressed through reset release SHALL register as a press (level 0->1, EVENT set) 2+DEBOUNCE_CYCLES edges after release.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-031 The bench SHALL cover: btn_n=4'b1110 held from edge 0 -> level[0]=1 and irq=1 after edge 6; STATUS read returns 8'h01.
REQ-032 The bench SHALL cover: btn_n[1] low for 3 cycles then high -> STATUS stays 8'h00, irq stays 0.
REQ-033 The bench SHALL cover: buttons 0 and 2 pressed and released, then an EVENT read -> rdata 8'h05 with rvalid one cycle after rd_en; a second EVENT read -> 8'h00; irq=0.
REQ-034 The bench SHALL cover: EVENT read on the same edge as a button 3 level rise with event=4'b0001 -> returns 8'h01; event afterwards = 4'b1000, irq stays 1.
REQ-035 The bench SHALL cover: a read of 16'hf000 -> rdata 8'h00, rvalid=1, EVENT unchanged.
REQ-036 The bench SHALL cover: reset asserted mid-debounce (counter=2) with a read pending -> all outputs 0 immediately, no rvalid after release, counter restarts from 0.
